// File: rtl/alu_dispatch_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// alu_dispatch_scheduler_pkg
// Shared definitions for the ALU dispatch buffer/scheduler:
//   ROB_INDEX_WIDTH      - width of a reorder-buffer index
//   PHY_REG_ADDR_WIDTH   - width of a physical register address
//   ALU_PAYLOAD_W        - width of the opaque op payload held per entry
//   alu_dispatch_entry_t - one buffered micro-op (payload, rob, prd, is_ctrl)
//   perf_sat_add()       - 32-bit saturating increment used by the
//                          optional performance counters
// -----------------------------------------------------------------------------
package alu_dispatch_scheduler_pkg;

   localparam int ROB_INDEX_WIDTH    = 6;
   localparam int PHY_REG_ADDR_WIDTH = 6;
   localparam int ALU_PAYLOAD_W      = 192;

   typedef struct packed {
      logic [ALU_PAYLOAD_W-1:0]      payload;
      logic [ROB_INDEX_WIDTH-1:0]    rob_index;
      logic [PHY_REG_ADDR_WIDTH-1:0] prd_addr;
      logic                          is_ctrl;
   } alu_dispatch_entry_t;

   // Add 0..3 to a 32-bit counter, sticking at all-ones instead of wrapping.
   function automatic logic [31:0] perf_sat_add(input logic [31:0] cnt,
                                                input logic [1:0]  inc);
      logic [32:0] sum;
      sum = {1'b0, cnt} + {31'd0, inc};
      if (sum[32]) begin
         perf_sat_add = 32'hFFFF_FFFF;
      end else begin
         perf_sat_add = sum[31:0];
      end
   endfunction

endpackage

// File: rtl/alu_dispatch_pick.sv
// -----------------------------------------------------------------------------
// alu_dispatch_pick
// Combinational issue decision for the two ALU lanes from the two oldest
// buffered entries.
// Ports:
//   count_i         - occupied entries in the buffer (registered)
//   head_is_ctrl_i  - oldest entry is a branch/jump
//   head1_is_ctrl_i - second-oldest entry is a branch/jump
//   alu1_rdy_i      - lane 1 accepts this cycle
//   alu2_rdy_i      - lane 2 accepts this cycle
//   flush_i         - flush in progress, suppress all issue
//   iss1_o          - oldest entry issues on lane 1
//   iss2_o          - second-oldest entry issues on lane 2
// -----------------------------------------------------------------------------
module alu_dispatch_pick #(
   parameter int DEPTH_WIDTH = 3
) (
   input  logic [DEPTH_WIDTH:0] count_i,
   input  logic                 head_is_ctrl_i,
   input  logic                 head1_is_ctrl_i,
   input  logic                 alu1_rdy_i,
   input  logic                 alu2_rdy_i,
   input  logic                 flush_i,
   output logic                 iss1_o,
   output logic                 iss2_o
);

   logic has_one_s;
   logic has_two_s;
   logic two_ctrl_s;

   // Lane 2 is only ever granted on top of lane 1 so issue stays in order,
   // and two branch/jumps never leave in the same cycle.
   always_comb begin
      has_one_s  = (count_i != (DEPTH_WIDTH+1)'(0));
      has_two_s  = (count_i >= (DEPTH_WIDTH+1)'(2));
      two_ctrl_s = head_is_ctrl_i & head1_is_ctrl_i;
      iss1_o     = has_one_s & alu1_rdy_i & ~flush_i;
      iss2_o     = iss1_o & has_two_s & alu2_rdy_i & ~two_ctrl_s;
   end

endmodule

// File: rtl/alu_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// alu_dispatch_scheduler
// In-order dispatch buffer feeding the two ALU lanes. Accepts one op per
// cycle from the RCU, issues up to two per cycle oldest-first (lane 1 always
// carries the older op), never two branch/jumps together, and drops all
// buffered ops on flush.
//
// Optional feature (macro ALU_DISPATCH_PERF_EN): three 32-bit saturating
// performance counters, cleared only by rst.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   enq_vld_i / enq_rdy_o     - enqueue handshake from the RCU
//   enq_payload_i, enq_rob_index_i, enq_prd_addr_i, enq_is_ctrl_i
//                             - op being enqueued
//   flush_i                   - discard every buffered op
//   alu1_rdy_i, alu2_rdy_i    - per-lane ready
//   aluN_req_valid_o, aluN_payload_o, aluN_rob_index_o, aluN_prd_addr_o
//                             - issue to lane N (combinational from the head)
//   count_o                   - occupied entries
//   perf_issue_cnt_o, perf_dual_cnt_o, perf_ctrl_stall_cnt_o
//                             - (ALU_DISPATCH_PERF_EN only) counters
// -----------------------------------------------------------------------------
module alu_dispatch_scheduler
   import alu_dispatch_scheduler_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int DEPTH_WIDTH = 3,
   parameter int PAYLOAD_W   = ALU_PAYLOAD_W  // must equal the package width
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enq_vld_i,
   output logic                          enq_rdy_o,
   input  logic [PAYLOAD_W-1:0]          enq_payload_i,
   input  logic [ROB_INDEX_WIDTH-1:0]    enq_rob_index_i,
   input  logic [PHY_REG_ADDR_WIDTH-1:0] enq_prd_addr_i,
   input  logic                          enq_is_ctrl_i,
   input  logic                          flush_i,
   input  logic                          alu1_rdy_i,
   input  logic                          alu2_rdy_i,
   output logic                          alu1_req_valid_o,
   output logic [PAYLOAD_W-1:0]          alu1_payload_o,
   output logic [ROB_INDEX_WIDTH-1:0]    alu1_rob_index_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] alu1_prd_addr_o,
   output logic                          alu2_req_valid_o,
   output logic [PAYLOAD_W-1:0]          alu2_payload_o,
   output logic [ROB_INDEX_WIDTH-1:0]    alu2_rob_index_o,
   output logic [PHY_REG_ADDR_WIDTH-1:0] alu2_prd_addr_o,
   output logic [DEPTH_WIDTH:0]          count_o
`ifdef ALU_DISPATCH_PERF_EN
   ,
   output logic [31:0]                   perf_issue_cnt_o,
   output logic [31:0]                   perf_dual_cnt_o,
   output logic [31:0]                   perf_ctrl_stall_cnt_o
`endif
);

   alu_dispatch_entry_t        entry_q [DEPTH];
   logic [DEPTH_WIDTH-1:0]     head_q;
   logic [DEPTH_WIDTH-1:0]     head_d;
   logic [DEPTH_WIDTH-1:0]     tail_q;
   logic [DEPTH_WIDTH-1:0]     tail_d;
   logic [DEPTH_WIDTH:0]       count_q;
   logic [DEPTH_WIDTH:0]       count_d;
   logic [DEPTH_WIDTH-1:0]     head1_s;
   alu_dispatch_entry_t        head_entry_s;
   alu_dispatch_entry_t        head1_entry_s;
   alu_dispatch_entry_t        enq_entry_s;
   logic                       enq_fire_s;
   logic                       iss1_s;
   logic                       iss2_s;

   // Head views, enqueue handshake and the entry to be written.
   always_comb begin
      head1_s       = head_q + DEPTH_WIDTH'(1);   // wraps modulo DEPTH
      head_entry_s  = entry_q[head_q];
      head1_entry_s = entry_q[head1_s];
      // Full check uses registered count only: no credit for same-cycle issue.
      enq_rdy_o     = (count_q != (DEPTH_WIDTH+1)'(DEPTH));
      enq_fire_s    = enq_vld_i & enq_rdy_o & ~flush_i;
      enq_entry_s.payload   = enq_payload_i;
      enq_entry_s.rob_index = enq_rob_index_i;
      enq_entry_s.prd_addr  = enq_prd_addr_i;
      enq_entry_s.is_ctrl   = enq_is_ctrl_i;
   end

   alu_dispatch_pick #(
      .DEPTH_WIDTH     (DEPTH_WIDTH)
   ) u_pick (
      .count_i         (count_q),
      .head_is_ctrl_i  (head_entry_s.is_ctrl),
      .head1_is_ctrl_i (head1_entry_s.is_ctrl),
      .alu1_rdy_i      (alu1_rdy_i),
      .alu2_rdy_i      (alu2_rdy_i),
      .flush_i         (flush_i),
      .iss1_o          (iss1_s),
      .iss2_o          (iss2_s)
   );

   // Pointer and occupancy next state; flush overrides everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = DEPTH_WIDTH'(0);
         tail_d  = DEPTH_WIDTH'(0);
         count_d = (DEPTH_WIDTH+1)'(0);
      end else begin
         case ({iss2_s, iss1_s})
            2'b01:   head_d = head_q + DEPTH_WIDTH'(1);
            2'b11:   head_d = head_q + DEPTH_WIDTH'(2);
            default: head_d = head_q;
         endcase
         if (enq_fire_s) begin
            tail_d = tail_q + DEPTH_WIDTH'(1);
         end else begin
            tail_d = tail_q;
         end
         count_d = count_q + (DEPTH_WIDTH+1)'(enq_fire_s)
                           - (DEPTH_WIDTH+1)'(iss1_s)
                           - (DEPTH_WIDTH+1)'(iss2_s);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= DEPTH_WIDTH'(0);
         tail_q  <= DEPTH_WIDTH'(0);
         count_q <= (DEPTH_WIDTH+1)'(0);
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (enq_fire_s) begin
         entry_q[tail_q] <= enq_entry_s;
      end
   end

   // Issue outputs: lane 1 always carries the older entry.
   always_comb begin
      alu1_req_valid_o = iss1_s;
      alu1_payload_o   = head_entry_s.payload;
      alu1_rob_index_o = head_entry_s.rob_index;
      alu1_prd_addr_o  = head_entry_s.prd_addr;
      alu2_req_valid_o = iss2_s;
      alu2_payload_o   = head1_entry_s.payload;
      alu2_rob_index_o = head1_entry_s.rob_index;
      alu2_prd_addr_o  = head1_entry_s.prd_addr;
      count_o          = count_q;
   end

`ifdef ALU_DISPATCH_PERF_EN
   logic [31:0] perf_issue_cnt_q;
   logic [31:0] perf_dual_cnt_q;
   logic [31:0] perf_ctrl_stall_cnt_q;
   logic        ctrl_stall_s;

   // A lane-2 slot lost only because both head entries are branch/jumps.
   always_comb begin
      ctrl_stall_s = (count_q >= (DEPTH_WIDTH+1)'(2)) & iss1_s & alu2_rdy_i &
                     head_entry_s.is_ctrl & head1_entry_s.is_ctrl;
   end

   // Saturating counters; flush deliberately does not clear them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_issue_cnt_q      <= 32'd0;
         perf_dual_cnt_q       <= 32'd0;
         perf_ctrl_stall_cnt_q <= 32'd0;
      end else begin
         perf_issue_cnt_q      <= perf_sat_add(perf_issue_cnt_q,
                                               {1'b0, iss1_s} + {1'b0, iss2_s});
         perf_dual_cnt_q       <= perf_sat_add(perf_dual_cnt_q, {1'b0, iss2_s});
         perf_ctrl_stall_cnt_q <= perf_sat_add(perf_ctrl_stall_cnt_q,
                                               {1'b0, ctrl_stall_s});
      end
   end

   // Counter outputs straight from their registers.
   always_comb begin
      perf_issue_cnt_o      = perf_issue_cnt_q;
      perf_dual_cnt_o       = perf_dual_cnt_q;
      perf_ctrl_stall_cnt_o = perf_ctrl_stall_cnt_q;
   end
`endif

endmodule

// File: tb/tb_alu_dispatch_scheduler.sv
module tb_alu_dispatch_scheduler;
   import alu_dispatch_scheduler_pkg::*;

   localparam int DEPTH = 8;
   localparam int DW    = 3;
   localparam int PW    = 192;
   localparam int RW    = ROB_INDEX_WIDTH;
   localparam int PRW   = PHY_REG_ADDR_WIDTH;

   logic           clk;
   logic           rst;
   logic           enq_vld_i;
   logic           enq_rdy_o;
   logic [PW-1:0]  enq_payload_i;
   logic [RW-1:0]  enq_rob_index_i;
   logic [PRW-1:0] enq_prd_addr_i;
   logic           enq_is_ctrl_i;
   logic           flush_i;
   logic           alu1_rdy_i;
   logic           alu2_rdy_i;
   logic           alu1_req_valid_o;
   logic [PW-1:0]  alu1_payload_o;
   logic [RW-1:0]  alu1_rob_index_o;
   logic [PRW-1:0] alu1_prd_addr_o;
   logic           alu2_req_valid_o;
   logic [PW-1:0]  alu2_payload_o;
   logic [RW-1:0]  alu2_rob_index_o;
   logic [PRW-1:0] alu2_prd_addr_o;
   logic [DW:0]    count_o;
`ifdef ALU_DISPATCH_PERF_EN
   logic [31:0]    perf_issue_cnt_o;
   logic [31:0]    perf_dual_cnt_o;
   logic [31:0]    perf_ctrl_stall_cnt_o;
`endif

   alu_dispatch_scheduler #(.DEPTH(DEPTH), .DEPTH_WIDTH(DW), .PAYLOAD_W(PW)) dut (
      .clk              (clk),
      .rst              (rst),
      .enq_vld_i        (enq_vld_i),
      .enq_rdy_o        (enq_rdy_o),
      .enq_payload_i    (enq_payload_i),
      .enq_rob_index_i  (enq_rob_index_i),
      .enq_prd_addr_i   (enq_prd_addr_i),
      .enq_is_ctrl_i    (enq_is_ctrl_i),
      .flush_i          (flush_i),
      .alu1_rdy_i       (alu1_rdy_i),
      .alu2_rdy_i       (alu2_rdy_i),
      .alu1_req_valid_o (alu1_req_valid_o),
      .alu1_payload_o   (alu1_payload_o),
      .alu1_rob_index_o (alu1_rob_index_o),
      .alu1_prd_addr_o  (alu1_prd_addr_o),
      .alu2_req_valid_o (alu2_req_valid_o),
      .alu2_payload_o   (alu2_payload_o),
      .alu2_rob_index_o (alu2_rob_index_o),
      .alu2_prd_addr_o  (alu2_prd_addr_o),
      .count_o          (count_o)
`ifdef ALU_DISPATCH_PERF_EN
      ,
      .perf_issue_cnt_o      (perf_issue_cnt_o),
      .perf_dual_cnt_o       (perf_dual_cnt_o),
      .perf_ctrl_stall_cnt_o (perf_ctrl_stall_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model: a plain FIFO of ops ----------------
   typedef struct {
      logic [RW-1:0]  rob;
      logic [PRW-1:0] prd;
      logic [PW-1:0]  pl;
      logic           ctrl;
   } op_t;

   op_t         mq[$];
   logic        m_e1;
   logic        m_e2;
   logic        m_stall;
   logic [31:0] pm_issue;
   logic [31:0] pm_dual;
   logic [31:0] pm_stall;
   int          errors;
   int          checks;

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk_pl(input logic [RW-1:0] r);
      mk_pl = {6{r, r, r, r, r, 2'b10}};
   endfunction

   // Per-cycle compare against the FIFO model (outputs settled mid-cycle).
   always @(negedge clk) begin
      int   n;
      logic bc;
      if (rst) begin
         mq.delete();
         pm_issue = 32'd0;
         pm_dual  = 32'd0;
         pm_stall = 32'd0;
      end
      n  = mq.size();
      bc = 1'b0;
      if (n >= 2) bc = mq[0].ctrl && mq[1].ctrl;
      m_e1    = !rst && (n >= 1) && alu1_rdy_i && !flush_i;
      m_e2    = m_e1 && (n >= 2) && alu2_rdy_i && !bc;
      m_stall = (n >= 2) && m_e1 && alu2_rdy_i && bc;
      chk("m_alu1_valid", {191'd0, alu1_req_valid_o}, {191'd0, m_e1});
      chk("m_alu2_valid", {191'd0, alu2_req_valid_o}, {191'd0, m_e2});
      chk("m_count", PW'(count_o), PW'(n));
      chk("m_enq_rdy", {191'd0, enq_rdy_o}, {191'd0, (n != DEPTH)});
      if (m_e1) begin
         chk("m_alu1_rob", PW'(alu1_rob_index_o), PW'(mq[0].rob));
         chk("m_alu1_prd", PW'(alu1_prd_addr_o), PW'(mq[0].prd));
         chk("m_alu1_payload", alu1_payload_o, mq[0].pl);
      end
      if (m_e2) begin
         chk("m_alu2_rob", PW'(alu2_rob_index_o), PW'(mq[1].rob));
         chk("m_alu2_prd", PW'(alu2_prd_addr_o), PW'(mq[1].prd));
         chk("m_alu2_payload", alu2_payload_o, mq[1].pl);
      end
`ifdef ALU_DISPATCH_PERF_EN
      chk("m_perf_issue", PW'(perf_issue_cnt_o), PW'(pm_issue));
      chk("m_perf_dual", PW'(perf_dual_cnt_o), PW'(pm_dual));
      chk("m_perf_stall", PW'(perf_ctrl_stall_cnt_o), PW'(pm_stall));
`endif
   end

   // Model state update at the clock edge.
   always @(posedge clk) begin
      int  n0;
      op_t o;
      if (rst) begin
         mq.delete();
         pm_issue = 32'd0;
         pm_dual  = 32'd0;
         pm_stall = 32'd0;
      end else if (flush_i) begin
         mq.delete();
      end else begin
         n0 = mq.size();
         if (m_e2) begin
            void'(mq.pop_front());
            void'(mq.pop_front());
         end else if (m_e1) begin
            void'(mq.pop_front());
         end
         if (enq_vld_i && (n0 != DEPTH)) begin
            o.rob  = enq_rob_index_i;
            o.prd  = enq_prd_addr_i;
            o.pl   = enq_payload_i;
            o.ctrl = enq_is_ctrl_i;
            mq.push_back(o);
         end
         pm_issue = pm_issue + 32'(m_e1) + 32'(m_e2);
         pm_dual  = pm_dual + 32'(m_e2);
         pm_stall = pm_stall + 32'(m_stall);
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input int r, input logic c);
      enq_vld_i       = 1'b1;
      enq_rob_index_i = RW'(r);
      enq_prd_addr_i  = PRW'(r ^ 42);
      enq_payload_i   = mk_pl(RW'(r));
      enq_is_ctrl_i   = c;
   endtask

   task automatic lit(input string name, input int act, input int exp);
      chk(name, PW'(act), PW'(exp));
   endtask

   initial begin
      errors = 0; checks = 0;
      rst = 1'b1; flush_i = 1'b0; enq_vld_i = 1'b0; enq_is_ctrl_i = 1'b0;
      enq_rob_index_i = '0; enq_prd_addr_i = '0; enq_payload_i = '0;
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0;
      tick(); tick();
      rst = 1'b0; #1;
      lit("rst_count", int'(count_o), 0);
      lit("rst_enq_rdy", int'(enq_rdy_o), 1);
      lit("rst_valid1", int'(alu1_req_valid_o), 0);

      // Three plain ops then dual + single issue.
      for (int i = 1; i <= 3; i++) begin enq(i, 1'b0); tick(); end
      enq_vld_i = 1'b0; alu1_rdy_i = 1'b1; alu2_rdy_i = 1'b1; #1;
      lit("t1_v1", int'(alu1_req_valid_o), 1);
      lit("t1_rob1", int'(alu1_rob_index_o), 1);
      lit("t1_v2", int'(alu2_req_valid_o), 1);
      lit("t1_rob2", int'(alu2_rob_index_o), 2);
      lit("t1_count", int'(count_o), 3);
      tick();
      lit("t1b_rob1", int'(alu1_rob_index_o), 3);
      lit("t1b_v2", int'(alu2_req_valid_o), 0);
      tick();
      lit("t1c_count", int'(count_o), 0);

      // Two branch/jumps: never together.
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0;
      enq(4, 1'b1); tick();
      enq(5, 1'b1); tick();
      enq_vld_i = 1'b0; alu1_rdy_i = 1'b1; alu2_rdy_i = 1'b1; #1;
      lit("t2_rob1", int'(alu1_rob_index_o), 4);
      lit("t2_v2", int'(alu2_req_valid_o), 0);
      tick();
      lit("t2b_v1", int'(alu1_req_valid_o), 1);
      lit("t2b_rob1", int'(alu1_rob_index_o), 5);
      tick();
      lit("t2c_count", int'(count_o), 0);
`ifdef ALU_DISPATCH_PERF_EN
      lit("t2_perf_stall", int'(perf_ctrl_stall_cnt_o), 1);
      lit("t2_perf_issue", int'(perf_issue_cnt_o), 5);
      lit("t2_perf_dual", int'(perf_dual_cnt_o), 1);
`endif

      // Fill to full, refuse a ninth, then drain on lane 1 only.
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0;
      for (int i = 0; i < 8; i++) begin enq(20 + i, 1'b0); tick(); end
      lit("t3_full_rdy", int'(enq_rdy_o), 0);
      lit("t3_full_count", int'(count_o), 8);
      enq(28, 1'b0); tick();
      lit("t3_refused", int'(count_o), 8);
      alu1_rdy_i = 1'b1; #1;
      lit("t3_rob1", int'(alu1_rob_index_o), 20);
      lit("t3_v2", int'(alu2_req_valid_o), 0);
      lit("t3_rdy_still0", int'(enq_rdy_o), 0);
      tick();
      enq_vld_i = 1'b0; #1;
      lit("t3_count7", int'(count_o), 7);
      lit("t3_rdy1", int'(enq_rdy_o), 1);
      lit("t3b_rob1", int'(alu1_rob_index_o), 21);
      repeat (5) tick();
      lit("t3_count2", int'(count_o), 2);

      // Lane 2 ready alone never issues.
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b1; #1;
      lit("t4_v1", int'(alu1_req_valid_o), 0);
      lit("t4_v2", int'(alu2_req_valid_o), 0);
      tick();
      lit("t4_count", int'(count_o), 2);

      // Flush at count 5 with a simultaneous enqueue.
      alu2_rdy_i = 1'b0;
      for (int i = 0; i < 3; i++) begin enq(30 + i, 1'b0); tick(); end
      enq(33, 1'b0); flush_i = 1'b1; alu1_rdy_i = 1'b1; alu2_rdy_i = 1'b1; #1;
      lit("t5_count5", int'(count_o), 5);
      lit("t5_v1", int'(alu1_req_valid_o), 0);
      lit("t5_v2", int'(alu2_req_valid_o), 0);
      tick();
      flush_i = 1'b0; enq_vld_i = 1'b0; alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0; #1;
      lit("t5_count0", int'(count_o), 0);
      lit("t5_rdy", int'(enq_rdy_o), 1);

      // Walk head to 7, then dual issue across the wrap.
      for (int i = 0; i < 7; i++) begin enq(40 + i, (i == 1) || (i == 2)); tick(); end
      enq_vld_i = 1'b0; alu1_rdy_i = 1'b1; alu2_rdy_i = 1'b1;
      repeat (4) tick();
      lit("t6_drained", int'(count_o), 0);
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0;
      enq(10, 1'b0); tick();
      enq(11, 1'b0); tick();
      enq_vld_i = 1'b0; alu1_rdy_i = 1'b1; alu2_rdy_i = 1'b1; #1;
      lit("t6_rob1", int'(alu1_rob_index_o), 10);
      lit("t6_rob2", int'(alu2_rob_index_o), 11);
      lit("t6_v2", int'(alu2_req_valid_o), 1);
      tick();
      lit("t6_count0", int'(count_o), 0);
      enq(12, 1'b0); tick();
      enq_vld_i = 1'b0; #1;
      lit("t6_after_wrap", int'(alu1_rob_index_o), 12);
      tick();

      // Asynchronous reset in the middle of a cycle.
      alu1_rdy_i = 1'b0; alu2_rdy_i = 1'b0;
      for (int i = 0; i < 4; i++) begin enq(50 + i, 1'b0); tick(); end
      enq_vld_i = 1'b0; alu1_rdy_i = 1'b1; #1;
      lit("t7_pre_v1", int'(alu1_req_valid_o), 1);
      lit("t7_pre_count", int'(count_o), 4);
      rst = 1'b1; #1;
      lit("t7_v1", int'(alu1_req_valid_o), 0);
      lit("t7_v2", int'(alu2_req_valid_o), 0);
      lit("t7_count", int'(count_o), 0);
      lit("t7_rdy", int'(enq_rdy_o), 1);
      tick();
      rst = 1'b0; alu1_rdy_i = 1'b0; #1;
      lit("t7_after", int'(count_o), 0);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_dispatch_scheduler.md
Name: alu_dispatch_scheduler

Overview:
- In-order dispatch buffer and scheduler for the two ALU lanes (alu1/alu2) of the functional-unit cluster.
- Accepts one ALU micro-op per cycle from the RCU and issues up to two per cycle, oldest first.
- Never issues more than one branch/jump per cycle and honours per-lane ready.
- Supports a flush from the RCU on mispredict or trap.

Parameters:
DEPTH, 8, number of buffer entries (power of two, >= 2)
DEPTH_WIDTH, 3, log2(DEPTH)
PAYLOAD_W, 192, opaque op payload width (operands, imm, selects, pc, func3, modifier, half)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
enq_vld_i  in  1  RCU offers an op
enq_rdy_o  out  1  buffer can accept
enq_payload_i  in  PAYLOAD_W  op payload
enq_rob_index_i  in  ROB_INDEX_WIDTH  ROB index
enq_prd_addr_i  in  PHY_REG_ADDR_WIDTH  destination physical register
enq_is_ctrl_i  in  1  op is branch or jump
flush_i  in  1  discard all buffered ops
alu1_rdy_i  in  1  lane 1 accepts this cycle
alu2_rdy_i  in  1  lane 2 accepts this cycle
alu1_req_valid_o  out  1  lane 1 issue
alu1_payload_o  out  PAYLOAD_W  lane 1 payload
alu1_rob_index_o  out  ROB_INDEX_WIDTH  lane 1 ROB index
alu1_prd_addr_o  out  PHY_REG_ADDR_WIDTH  lane 1 prd
alu2_req_valid_o  out  1  lane 2 issue
alu2_payload_o  out  PAYLOAD_W  lane 2 payload
alu2_rob_index_o  out  ROB_INDEX_WIDTH  lane 2 ROB index
alu2_prd_addr_o  out  PHY_REG_ADDR_WIDTH  lane 2 prd
count_o  out  DEPTH_WIDTH+1  occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries.
  - head and tail pointers are DEPTH_WIDTH bits and wrap modulo DEPTH.
  - count is registered, range 0..DEPTH.
- Reset (async, rst=1): head=0, tail=0, count=0, all entry valid bits 0.
  - Consequently enq_rdy_o=1, both req_valid_o=0, count_o=0.
  - Payload outputs are don't-care while the matching valid is 0.
- Enqueue:
  - enq_rdy_o = (count != DEPTH). It depends on registered count only and takes no credit for same-cycle issue.
  - Handshake at enq_vld_i & enq_rdy_o & ~flush_i writes entry[tail] and advances tail by 1.
  - An op enqueued in cycle T is issuable no earlier than T+1; there is no bypass.
- Issue: outputs are combinational from entry[head] and entry[head+1].
  - iss1 = count>=1 & alu1_rdy_i & ~flush_i.
  - iss2 = iss1 & count>=2 & alu2_rdy_i & ~(head.is_ctrl & head1.is_ctrl).
  - Lane 2 never issues without lane 1. This keeps issue strictly in order.
  - alu1 always carries the older op.
  - alu*_req_valid_o = iss1 / iss2. Issue is final on valid; the ALUs have no further backpressure.
  - head advances by iss1+iss2.
- Count update: count_next = count + enq_fire - iss1 - iss2.
  - With simultaneous enqueue and dual issue, the net is -1.
  - With a full buffer plus issue, enqueue is still refused that cycle (enq_rdy_o=0).
- Flush:
  - flush_i=1 forces both valids to 0 in that cycle and drops any enqueue offered that cycle.
  - On the next edge: head=tail=0, count=0.
  - Flush has priority over all other updates.
- Wrap-around: head+1 wraps modulo DEPTH; two entries straddling index DEPTH-1/0 dual-issue normally.
- Empty: no valids. count=1: single issue only.

Optional Feature:
- Macro ALU_DISPATCH_PERF_EN.
- When defined, adds three 32-bit saturating counters, cleared by rst and not by flush:
  - perf_issue_cnt_o: += iss1+iss2.
  - perf_dual_cnt_o: += iss2.
  - perf_ctrl_stall_cnt_o: += 1 when count>=2 & iss1 & alu2_rdy_i & both head entries are ctrl.
- The three counters are exported as output ports.
- When not defined, the counters and their ports are absent and the rest of the behaviour is identical.

Decomposition:
- Shared core package: ROB_INDEX_WIDTH, PHY_REG_ADDR_WIDTH, and a packed alu_dispatch_entry_t (payload, rob_index, prd_addr, is_ctrl).
- Sub-module alu_dispatch_pick: combinational iss1/iss2 computation from the two head entries, count and ready inputs.
- Storage and pointer logic stay in the top.

Test Plan:
- Reset then enqueue 3 non-ctrl ops (rob 1,2,3) with both rdy=1: T+1 alu1=rob1 and alu2=rob2; T+2 alu1=rob3 only; count returns to 0.
- Two consecutive ctrl ops rob 4,5 with both rdy=1: cycle 1 issues only rob4 on alu1; cycle 2 issues rob5 on alu1; perf_ctrl_stall_cnt=1 when the macro is defined.
- Fill to 8 with both rdy=0: enq_rdy_o=0 and a 9th offer is not accepted; raise alu1_rdy_i only: one issue per cycle, enq_rdy_o=1 one cycle after the first issue.
- alu1_rdy_i=0, alu2_rdy_i=1, count=2: no issue on either lane.
- Flush with count=5 and a simultaneous enqueue: valids=0 that cycle; next cycle count=0, the enqueued op is lost, enq_rdy_o=1.
- Pointer wrap with head=7 and count=2 (entries rob 10 at index 7, rob 11 at index 0): dual issue alu1=rob10, alu2=rob11; head=1.
- Assert rst asynchronously mid-stream with count=4: outputs drop immediately (valids=0, count_o=0).
